// File: rtl/clause_bcp_if.sv
// clause_bcp_if: bundles the evaluation handshake, chain sample inputs and
// result outputs of the clause BCP controller.
// Optional macro CLAUSE_BCP_ERR_EN adds the sticky err_o flag.
interface clause_bcp_if #(
   parameter int NUM_LITS = 8,
   parameter int CNT_W    = 16
);
   // stimulus side (driven by the master)
   logic                start_i;
   logic [1:0]          freelitcnt_i;
   logic [NUM_LITS-1:0] clausesat_i;
   logic                clr_i;
   logic                imp_ready_i;
   // result side (driven by the controller)
   logic                imp_valid_o;
   logic                imp_drv_o;
   logic                cclause_drv_o;
   logic                conflict_o;
   logic                busy_o;
   logic                done_o;
   logic [1:0]          status_o;
   logic [CNT_W-1:0]    imp_cnt_o;
`ifdef CLAUSE_BCP_ERR_EN
   logic                err_o;
`endif

   modport master (
      output start_i, freelitcnt_i, clausesat_i, clr_i, imp_ready_i,
      input  imp_valid_o, imp_drv_o, cclause_drv_o, conflict_o,
             busy_o, done_o, status_o, imp_cnt_o
`ifdef CLAUSE_BCP_ERR_EN
      , input err_o
`endif
   );

   modport slave (
      input  start_i, freelitcnt_i, clausesat_i, clr_i, imp_ready_i,
      output imp_valid_o, imp_drv_o, cclause_drv_o, conflict_o,
             busy_o, done_o, status_o, imp_cnt_o
`ifdef CLAUSE_BCP_ERR_EN
      , output err_o
`endif
   );
endinterface

// File: rtl/clause_bcp_ctrl.sv
// clause_bcp_ctrl: clause-level controller for a chain of literal cells.
// After a start pulse it waits SETTLE_CYCLES for the combinational chain to
// ripple, then classifies the clause as sat, unit, conflict or unresolved,
// drives the imp/cclause broadcast lines and hands implications upstream.
// Optional macro CLAUSE_BCP_ERR_EN: sticky err_o on an illegal freelitcnt of 2.
module clause_bcp_ctrl #(
   parameter int NUM_LITS      = 8,
   parameter int SETTLE_CYCLES = 1,
   parameter int CNT_W         = 16
) (
   input  logic         clk,
   input  logic         rst,
   clause_bcp_if.slave  bus
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETTLE = 3'd1,
      ST_EVAL   = 3'd2,
      ST_IMP    = 3'd3,
      ST_CONFL  = 3'd4
   } state_t;

   localparam logic [1:0] STATUS_UNRES = 2'd0;
   localparam logic [1:0] STATUS_SAT   = 2'd1;
   localparam logic [1:0] STATUS_UNIT  = 2'd2;
   localparam logic [1:0] STATUS_CONFL = 2'd3;

   // settle counter is loaded with SETTLE_CYCLES-1 so SETTLE lasts exactly SETTLE_CYCLES
   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

   // saturating increment for the implication counter
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      logic [CNT_W-1:0] r;
      if (v == {CNT_W{1'b1}}) begin
         r = v;
      end else begin
         r = v + CNT_W'(1);
      end
      return r;
   endfunction

   state_t              state_q, state_d;
   logic [3:0]          settle_q, settle_d;
   logic                imp_valid_q, imp_valid_d;
   logic                imp_drv_q, imp_drv_d;
   logic                cclause_drv_q, cclause_drv_d;
   logic                conflict_q, conflict_d;
   logic                done_q, done_d;
   logic [1:0]          status_q, status_d;
   logic [CNT_W-1:0]    imp_cnt_q, imp_cnt_d;
`ifdef CLAUSE_BCP_ERR_EN
   logic                err_q, err_d;
`endif

   logic [NUM_LITS-1:0] clausesat_s;
   logic                any_sat_s;

   assign clausesat_s = bus.clausesat_i;
   assign any_sat_s   = |clausesat_s;

   // state and output registers; reset drops the broadcast lines immediately
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         settle_q      <= 4'd0;
         imp_valid_q   <= 1'b0;
         imp_drv_q     <= 1'b0;
         cclause_drv_q <= 1'b0;
         conflict_q    <= 1'b0;
         done_q        <= 1'b0;
         status_q      <= 2'd0;
         imp_cnt_q     <= {CNT_W{1'b0}};
`ifdef CLAUSE_BCP_ERR_EN
         err_q         <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         settle_q      <= settle_d;
         imp_valid_q   <= imp_valid_d;
         imp_drv_q     <= imp_drv_d;
         cclause_drv_q <= cclause_drv_d;
         conflict_q    <= conflict_d;
         done_q        <= done_d;
         status_q      <= status_d;
         imp_cnt_q     <= imp_cnt_d;
`ifdef CLAUSE_BCP_ERR_EN
         err_q         <= err_d;
`endif
      end
   end

   // next-state and next-output decode; start_i outside IDLE is dropped
   always_comb begin
      state_d       = state_q;
      settle_d      = settle_q;
      imp_valid_d   = imp_valid_q;
      imp_drv_d     = 1'b0;
      cclause_drv_d = cclause_drv_q;
      conflict_d    = conflict_q;
      done_d        = 1'b0;
      status_d      = status_q;
      imp_cnt_d     = imp_cnt_q;
`ifdef CLAUSE_BCP_ERR_EN
      err_d         = err_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (bus.start_i) begin
               settle_d = SETTLE_LOAD;
               state_d  = ST_SETTLE;
            end else begin
               state_d  = ST_IDLE;
            end
         end

         ST_SETTLE: begin
            if (settle_q == 4'd0) begin
               state_d  = ST_EVAL;
            end else begin
               settle_d = settle_q - 4'd1;
            end
         end

         ST_EVAL: begin
            // a satisfied literal outranks whatever the free-literal tail says
            if (any_sat_s) begin
               status_d = STATUS_SAT;
               done_d   = 1'b1;
               state_d  = ST_IDLE;
            end else begin
               case (bus.freelitcnt_i)
                  2'd0: begin
                     status_d      = STATUS_CONFL;
                     conflict_d    = 1'b1;
                     cclause_drv_d = 1'b1;
                     done_d        = 1'b1;
                     state_d       = ST_CONFL;
                  end
                  2'd1: begin
                     imp_valid_d   = 1'b1;
                     state_d       = ST_IMP;
                  end
                  default: begin
                     // 2 is illegal and handled like 3 (two or more free)
                     status_d      = STATUS_UNRES;
                     done_d        = 1'b1;
                     state_d       = ST_IDLE;
`ifdef CLAUSE_BCP_ERR_EN
                     if (bus.freelitcnt_i == 2'd2) begin
                        err_d = 1'b1;
                     end else begin
                        err_d = err_q;
                     end
`endif
                  end
               endcase
            end
         end

         ST_IMP: begin
            if (bus.imp_ready_i) begin
               imp_valid_d = 1'b0;
               imp_drv_d   = 1'b1;
               status_d    = STATUS_UNIT;
               done_d      = 1'b1;
               imp_cnt_d   = sat_inc(imp_cnt_q);
               state_d     = ST_IDLE;
            end else begin
               state_d     = ST_IMP;
            end
         end

         ST_CONFL: begin
            // status keeps the conflict code after the clear
            if (bus.clr_i) begin
               conflict_d    = 1'b0;
               cclause_drv_d = 1'b0;
               state_d       = ST_IDLE;
            end else begin
               state_d       = ST_CONFL;
            end
         end

         default: begin
            // unreachable encoding: recover to a quiet IDLE
            state_d       = ST_IDLE;
            imp_valid_d   = 1'b0;
            cclause_drv_d = 1'b0;
            conflict_d    = 1'b0;
         end
      endcase
   end

   assign bus.imp_valid_o   = imp_valid_q;
   assign bus.imp_drv_o     = imp_drv_q;
   assign bus.cclause_drv_o = cclause_drv_q;
   assign bus.conflict_o    = conflict_q;
   assign bus.busy_o        = (state_q != ST_IDLE);
   assign bus.done_o        = done_q;
   assign bus.status_o      = status_q;
   assign bus.imp_cnt_o     = imp_cnt_q;
`ifdef CLAUSE_BCP_ERR_EN
   assign bus.err_o         = err_q;
`endif

endmodule
